// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: FSM state encoding and datapath widths
// used by the sequential multiplier/accumulator and its adder.
package alu_pkg;

    localparam int DW        = 32;
    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL    = 3'd1,
        ST_ACC_LO = 3'd2,
        ST_ACC_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/mac32_seq_if.sv
// Request/result bundle of mac32_seq; the requester is master, the unit slave.
interface mac32_seq_if;

    logic        start;
    logic        mac;
    logic        clr;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic [63:0] acc;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output start, mac, clr, a, b,
        input  p, acc, busy, done, ovf
    );

    modport slave (
        input  start, mac, clr, a, b,
        output p, acc, busy, done, ovf
    );

endinterface

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32
    import alu_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          ci_i,
    output logic [DW-1:0] sum_o,
    output logic          co_o
);

    logic [DW-1:0] gen;
    logic [DW-1:0] prop;
    logic [DW:0]   c;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;
    assign c[0] = ci_i;

    for (genvar j = 0; j < DW / 4; j++) begin : g_grp
        localparam int B = 4 * j;
        assign c[B+1] = gen[B] | (prop[B] & c[B]);
        assign c[B+2] = gen[B+1] | (prop[B+1] & gen[B]) | (prop[B+1] & prop[B] & c[B]);
        assign c[B+3] = gen[B+2] | (prop[B+2] & gen[B+1]) | (prop[B+2] & prop[B+1] & gen[B])
                      | (prop[B+2] & prop[B+1] & prop[B] & c[B]);
        assign c[B+4] = gen[B+3] | (prop[B+3] & gen[B+2]) | (prop[B+3] & prop[B+2] & gen[B+1])
                      | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B])
                      | (prop[B+3] & prop[B+2] & prop[B+1] & prop[B] & c[B]);
    end

    assign sum_o = prop ^ c[DW-1:0];
    assign co_o  = c[DW];

endmodule

// File: rtl/mac32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with optional 64-bit
// accumulate; a single cla32 is time-shared by all iterations and both half-adds.
module mac32_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    mac32_seq_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DW-1:0]     prod_q, prod_d;
    logic [2*DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]       a_q, a_d;
    logic                mac_q, mac_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, done_q;

    logic [DW-1:0]       add_a, add_b, add_sum;
    logic                add_ci, add_co;

    cla32 u_cla (
        .a_i   (add_a),
        .b_i   (add_b),
        .ci_i  (add_ci),
        .sum_o (add_sum),
        .co_o  (add_co)
    );

    // Operand selection depends on state alone, never on the adder's own output.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        unique case (state_q)
            ST_MUL:    begin add_a = prod_q[2*DW-1:DW]; add_b = a_q;               end
            ST_ACC_LO: begin add_a = acc_q[DW-1:0];     add_b = prod_q[DW-1:0];    end
            ST_ACC_HI: begin add_a = acc_q[2*DW-1:DW];  add_b = prod_q[2*DW-1:DW];
                             add_ci = carry_q;                                     end
            default:   ;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        a_d     = a_q;
        mac_d   = mac_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                if (bus.start) begin
                    a_d     = bus.a;
                    mac_d   = bus.mac;
                    prod_d  = {{DW{1'b0}}, bus.b};
                    cnt_d   = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                prod_d = prod_q[0] ? {add_co, add_sum, prod_q[DW-1:1]}
                                   : {1'b0, prod_q[2*DW-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_ITERS - 1))
                    state_d = mac_q ? ST_ACC_LO : ST_DONE;
            end
            ST_ACC_LO: begin
                acc_d[DW-1:0] = add_sum;
                carry_d       = add_co;
                state_d       = ST_ACC_HI;
            end
            ST_ACC_HI: begin
                acc_d[2*DW-1:DW] = add_sum;
                if (add_co) ovf_d = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            mac_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            mac_q   <= mac_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.p    = prod_q;
    assign bus.acc  = acc_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mac32_seq.sv
// Self-checking bench for mac32_seq: per-cycle comparison against an
// arithmetic model, plus directed literal expectations and random operations.
module tb_mac32_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac32_seq_if bus ();

    mac32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    // Product register after k shift-add steps: the partial product of the low
    // k multiplier bits sits above the multiplier bits not yet consumed.
    function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] a64, b64, lowb;
        a64  = {32'b0, a};
        b64  = {32'b0, b};
        lowb = b64 & ((64'd1 << k) - 64'd1);
        return ((a64 * lowb) << (32 - k)) + (b64 >> k);
    endfunction

    // Model: m_cnt is the cycle number since the accepted start (0 = idle).
    int          m_cnt = 0;
    logic [31:0] m_a   = '0;
    logic [31:0] m_b   = '0;
    logic        m_mac = 1'b0;
    logic [63:0] m_p   = '0;
    logic [63:0] m_acc = '0;
    logic        m_ovf = 1'b0;
    logic [64:0] m_sum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_a = '0; m_b = '0; m_mac = 1'b0;
            m_p = '0; m_acc = '0; m_ovf = 1'b0; m_sum = '0;
        end else begin
            if (m_cnt == 0) begin
                if (bus.clr) begin m_acc = '0; m_ovf = 1'b0; end
                if (bus.start) begin
                    m_a = bus.a; m_b = bus.b; m_mac = bus.mac; m_cnt = 1;
                end
            end else if (m_cnt == (m_mac ? 35 : 33)) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (m_cnt >= 1 && m_cnt <= 33) m_p = partial(m_a, m_b, m_cnt - 1);
            if (m_mac && m_cnt == 34) begin
                m_sum = {1'b0, m_acc} + {1'b0, m_p};
                m_acc[31:0] = m_sum[31:0];
            end
            if (m_mac && m_cnt == 35) begin
                m_acc[63:32] = m_sum[63:32];
                m_ovf = m_ovf | m_sum[64];
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", 64'(bus.busy), 64'(m_cnt != 0));
        check("cyc_done", 64'(bus.done), 64'(m_cnt != 0 && m_cnt == (m_mac ? 35 : 33)));
        check("cyc_p",    bus.p,         m_p);
        check("cyc_acc",  bus.acc,       m_acc);
        check("cyc_ovf",  64'(bus.ovf),  64'(m_ovf));
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic mac,
                          input logic clr, output int lat);
        int n0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mac = mac; bus.clr = clr; bus.a = a; bus.b = b;
        n0 = edge_cnt;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.clr = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = edge_cnt - n0;
                break;
            end
        end
    endtask

    task automatic do_clr();
        @(posedge clk); #1; bus.clr = 1'b1;
        @(posedge clk); #1; bus.clr = 1'b0;
    endtask

    initial begin
        int lat;
        int n0;
        int n_done;
        logic [31:0] ra, rb;
        logic        rmac, rclr;

        bus.start = 1'b0; bus.mac = 1'b0; bus.clr = 1'b0; bus.a = '0; bus.b = '0;
        #1;
        check("rst_p",    bus.p,   64'd0);
        check("rst_acc",  bus.acc, 64'd0);
        check("rst_flags", {61'd0, bus.busy, bus.done, bus.ovf}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(32'd3, 32'd5, 1'b0, 1'b0, lat);
        check("mul_3x5_p",   bus.p, 64'h0000_0000_0000_000F);
        check("mul_3x5_lat", 64'(lat), 64'd33);
        check("mul_3x5_acc", bus.acc, 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
        check("mul_max_p", bus.p, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
        check("mul_zero_p", bus.p, 64'd0);

        run_op(32'h1_0000, 32'h1_0000, 1'b1, 1'b1, lat);
        check("mac_clr_acc", bus.acc, 64'h1_0000_0000);
        run_op(32'd7, 32'd9, 1'b1, 1'b0, lat);
        check("mac_7x9_acc", bus.acc, 64'h1_0000_003F);
        check("mac_7x9_lat", 64'(lat), 64'd35);

        do_clr();
        for (int i = 1; i <= 3; i++) begin
            run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
            if (i == 2) check("ovf_acc2", bus.acc, 64'hFFFF_FFFC_0000_0002);
        end
        // 2*p already exceeds 2^64, so the carry out of the high half is sticky by now.
        check("ovf_acc3", bus.acc, 64'hFFFF_FFFA_0000_0003);
        check("ovf_set3", 64'(bus.ovf), 64'd1);
        run_op(32'd2, 32'd3, 1'b0, 1'b0, lat);
        check("ovf_sticky", 64'(bus.ovf), 64'd1);
        do_clr();
        check("clr_acc", bus.acc, 64'd0);
        check("clr_ovf", 64'(bus.ovf), 64'd0);

        run_op(32'd5, 32'd5, 1'b1, 1'b0, lat);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mac = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h100;
        n0 = edge_cnt;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.clr = 1'b1; bus.mac = 1'b0;
        bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
        @(posedge clk); #1; bus.start = 1'b0; bus.clr = 1'b0;
        n_done = 0;
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (lat < 0) lat = edge_cnt - n0;
            end
        end
        check("ign_p",     bus.p,   64'h12_3456_7800);
        check("ign_acc",   bus.acc, 64'h12_3456_7819);
        check("ign_ndone", 64'(n_done), 64'd1);
        check("ign_lat",   64'(lat), 64'd35);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.mac = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_p",     bus.p,   64'd0);
        check("rstmid_acc",   bus.acc, 64'd0);
        check("rstmid_flags", {61'd0, bus.busy, bus.done, bus.ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd6, 32'd7, 1'b0, 1'b0, lat);
        check("rstmid_6x7_p",   bus.p, 64'd42);
        check("rstmid_6x7_lat", 64'(lat), 64'd33);

        for (int i = 0; i < 24; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 4))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h0;
                default: ;
            endcase
            rmac = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(ra, rb, rmac, rclr, lat);
            check("rnd_p",   bus.p, {32'd0, ra} * {32'd0, rb});
            check("rnd_lat", 64'(lat), rmac ? 64'd35 : 64'd33);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
